// File: rtl/int_res_mem_arbiter_pkg.sv
// Shared types and sizing for the intermediate-result memory arbiter.
package int_res_mem_arbiter_pkg;

  localparam int CIM_INT_RES_NUM_BANKS          = 4;
  localparam int CIM_INT_RES_BANK_SIZE_NUM_WORD = 14336;
  localparam int N_STO_INT_RES                  = 15;
  localparam int NUM_INT_RES_WORDS = CIM_INT_RES_NUM_BANKS * CIM_INT_RES_BANK_SIZE_NUM_WORD;

  typedef logic [$clog2(NUM_INT_RES_WORDS)-1:0]              IntResAddr_t;
  typedef logic [$clog2(CIM_INT_RES_BANK_SIZE_NUM_WORD)-1:0] IntResBankAddr_t;

  typedef enum logic {
    SINGLE_WIDTH = 1'b0,
    DOUBLE_WIDTH = 1'b1
  } DataWidth_t;

  typedef struct packed {
    logic                         write;
    DataWidth_t                   width;
    IntResAddr_t                  addr;
    logic [2*N_STO_INT_RES-1:0]   wdata;
  } MemReq_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/int_res_mem_arbiter_if.sv
// Requester-side bus of the arbiter: per-requester request lanes plus a shared response.
interface int_res_mem_arbiter_if
  import int_res_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N_STO   = N_STO_INT_RES
);
  logic        [NUM_REQ-1:0]              req_valid;
  logic        [NUM_REQ-1:0]              req_ready;
  logic        [NUM_REQ-1:0]              req_write;
  DataWidth_t  [NUM_REQ-1:0]              req_width;
  IntResAddr_t [NUM_REQ-1:0]              req_addr;
  logic        [NUM_REQ-1:0][2*N_STO-1:0] req_wdata;
  logic        [NUM_REQ-1:0]              rsp_valid;
  logic        [2*N_STO-1:0]              rsp_rdata;
  logic                                   rsp_err;

  modport master (
    output req_valid, req_write, req_width, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_width, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/int_res_addr_decode.sv
// Flat word address -> one-hot bank, address within bank, out-of-range flag.
module int_res_addr_decode
  import int_res_mem_arbiter_pkg::*;
#(
  parameter int NUM_BANKS  = CIM_INT_RES_NUM_BANKS,
  parameter int BANK_WORDS = CIM_INT_RES_BANK_SIZE_NUM_WORD
) (
  input  IntResAddr_t           addr,
  output logic [NUM_BANKS-1:0]  bank_oh,
  output IntResBankAddr_t       bank_addr,
  output logic                  oor
);

  IntResBankAddr_t offset [NUM_BANKS];

  // Range compare against constant bank boundaries instead of dividing.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam int LO = gi * BANK_WORDS;
      localparam int HI = (gi + 1) * BANK_WORDS;
      assign bank_oh[gi] = (int'(addr) >= LO) && (int'(addr) < HI);
      assign offset[gi]  = IntResBankAddr_t'(int'(addr) - LO);
    end
  endgenerate

  always_comb begin
    bank_addr = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_oh[i]) bank_addr = offset[i];
    end
  end

  assign oor = ~|bank_oh;

endmodule

// File: rtl/int_res_mem_arbiter.sv
// Round-robin arbiter sharing the banked intermediate-result memory; double words take two bank accesses.
module int_res_mem_arbiter
  import int_res_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_BANKS  = CIM_INT_RES_NUM_BANKS,
  parameter int BANK_WORDS = CIM_INT_RES_BANK_SIZE_NUM_WORD,
  parameter int N_STO      = N_STO_INT_RES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  int_res_mem_arbiter_if.slave               bus,
  output logic [NUM_BANKS-1:0]               bank_en,
  output logic                               bank_we,
  output IntResBankAddr_t                    bank_addr,
  output logic [N_STO-1:0]                   bank_wdata,
  input  logic [NUM_BANKS-1:0][N_STO-1:0]    bank_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_reg, state_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [PW-1:0]      owner_reg, owner_next;
  MemReq_t            cur_reg, cur_next;
  logic [N_STO-1:0]   upper_reg, upper_next;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      winner;

  logic [NUM_BANKS-1:0] dec_a_oh, dec_b_oh;
  IntResBankAddr_t      dec_a_addr, dec_b_addr;
  logic                 dec_a_oor, dec_b_oor;
  logic                 is_double, err;
  logic [N_STO-1:0]     word_a, word_b;

  int_res_addr_decode #(.NUM_BANKS(NUM_BANKS), .BANK_WORDS(BANK_WORDS)) u_dec_a (
    .addr(cur_reg.addr), .bank_oh(dec_a_oh), .bank_addr(dec_a_addr), .oor(dec_a_oor)
  );

  int_res_addr_decode #(.NUM_BANKS(NUM_BANKS), .BANK_WORDS(BANK_WORDS)) u_dec_b (
    .addr(cur_reg.addr + IntResAddr_t'(1)), .bank_oh(dec_b_oh), .bank_addr(dec_b_addr), .oor(dec_b_oor)
  );

  assign is_double = (cur_reg.width == DOUBLE_WIDTH);
  assign err       = dec_a_oor | (is_double & dec_b_oor);

  // First valid requester at or after the pointer; grant is held off during reset.
  always_comb begin
    logic found;
    logic [PW-1:0] idx;
    grant  = '0;
    winner = ptr_reg;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr_reg) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (state_reg == IDLE && rst_n && found) grant[winner] = 1'b1;
  end

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (dec_a_oh[i]) word_a = bank_rdata[i];
      if (dec_b_oh[i]) word_b = bank_rdata[i];
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    cur_next      = cur_reg;
    upper_next    = upper_reg;
    bank_en       = '0;
    bank_we       = 1'b0;
    bank_addr     = '0;
    bank_wdata    = '0;
    bus.req_ready = grant;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (|grant) begin
          owner_next = winner;
          ptr_next   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          cur_next   = '{write: bus.req_write[winner], width: bus.req_width[winner],
                         addr:  bus.req_addr[winner],  wdata: bus.req_wdata[winner]};
          state_next = ACC1;
        end
      end
      ACC1: begin
        bank_en    = err ? '0 : dec_a_oh;
        bank_we    = cur_reg.write & ~err;
        bank_addr  = dec_a_addr;
        bank_wdata = is_double ? cur_reg.wdata[2*N_STO-1:N_STO] : cur_reg.wdata[N_STO-1:0];
        state_next = is_double ? ACC2 : RESP;
      end
      ACC2: begin
        bank_en    = err ? '0 : dec_b_oh;
        bank_we    = cur_reg.write & ~err;
        bank_addr  = dec_b_addr;
        bank_wdata = cur_reg.wdata[N_STO-1:0];
        upper_next = word_a;
        state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid[owner_reg] = 1'b1;
        bus.rsp_err              = err;
        if (!err && !cur_reg.write) begin
          bus.rsp_rdata = is_double ? {upper_reg, word_b} : {{N_STO{word_a[N_STO-1]}}, word_a};
        end
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cur_reg   <= '0;
      upper_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cur_reg   <= cur_next;
      upper_reg <= upper_next;
    end
  end

endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Scoreboard bench for int_res_mem_arbiter: directed vectors, expected bank accesses and responses queued at grant.
module tb_int_res_mem_arbiter;
  import int_res_mem_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NB = 4;
  localparam int BW = 14336;
  localparam int N  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_res_mem_arbiter_if #(.NUM_REQ(NR), .N_STO(N)) bus ();

  logic [NB-1:0]         bank_en;
  logic                  bank_we;
  IntResBankAddr_t       bank_addr;
  logic [N-1:0]          bank_wdata;
  logic [NB-1:0][N-1:0]  bank_rdata = '0;

  int_res_mem_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB), .BANK_WORDS(BW), .N_STO(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  // Bank memories with one-cycle registered read.
  logic [N-1:0] mem [NB][BW];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we) mem[b][bank_addr] <= bank_wdata;
        else         bank_rdata[b]     <= mem[b][bank_addr];
      end
    end
  end

  typedef struct {
    int             req;
    bit             write;
    bit             dbl;
    int             addr;
    logic [2*N-1:0] wdata;
    logic [NB-1:0]  en1;
    int             ba1;
    logic [NB-1:0]  en2;
    int             ba2;
    logic [2*N-1:0] rdata;
    bit             err;
    bit             rsp;
  } vec_t;

  typedef struct {
    int             owner;
    logic [2*N-1:0] rdata;
    bit             err;
    int             cyc;
  } rsp_t;

  typedef struct {
    logic [NB-1:0] en;
    bit            we;
    int            addr;
    logic [N-1:0]  wdata;
  } bank_t;

  rsp_t  exp_rsp_q[$];
  bank_t exp_bank_q[$];
  int    exp_grant_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    grant_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(int req, bit write, bit dbl, int addr, logic [2*N-1:0] wdata,
                              logic [NB-1:0] en1, int ba1, logic [NB-1:0] en2, int ba2,
                              logic [2*N-1:0] rdata, bit err, bit rsp = 1'b1);
    vec_t v;
    v.req = req; v.write = write; v.dbl = dbl; v.addr = addr; v.wdata = wdata;
    v.en1 = en1; v.ba1 = ba1; v.en2 = en2; v.ba2 = ba2;
    v.rdata = rdata; v.err = err; v.rsp = rsp;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    int    g0;
    int    gcyc;
    bit    got;
    bank_t b;
    rsp_t  r;
    bus.req_write[v.req] = v.write;
    bus.req_width[v.req] = v.dbl ? DOUBLE_WIDTH : SINGLE_WIDTH;
    bus.req_addr[v.req]  = IntResAddr_t'(v.addr);
    bus.req_wdata[v.req] = v.wdata;
    bus.req_valid[v.req] = 1'b1;
    g0  = grant_count;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ready[v.req]) got = 1'b1;
      else @(posedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_timeout: req %0d got no grant, required one", v.req);
      bus.req_valid[v.req] = 1'b0;
      return;
    end
    gcyc = cyc;
    grant_count++;
    chk("grant_wait", 64'(grant_count - g0 - 1 < NR), 64'(1));
    if (exp_grant_q.size() > 0) chk("grant_order", 64'(v.req), 64'(exp_grant_q.pop_front()));
    if (v.en1 != '0) begin
      b.en = v.en1; b.we = v.write; b.addr = v.ba1;
      b.wdata = v.dbl ? v.wdata[2*N-1:N] : v.wdata[N-1:0];
      exp_bank_q.push_back(b);
    end
    if (v.dbl && v.en2 != '0) begin
      b.en = v.en2; b.we = v.write; b.addr = v.ba2; b.wdata = v.wdata[N-1:0];
      exp_bank_q.push_back(b);
    end
    if (v.rsp) begin
      r.owner = v.req; r.rdata = v.rdata; r.err = v.err; r.cyc = gcyc + (v.dbl ? 3 : 2);
      exp_rsp_q.push_back(r);
    end
    @(posedge clk);
    #1 bus.req_valid[v.req] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_bank_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending rsp=%0d bank=%0d, required 0", exp_rsp_q.size(), exp_bank_q.size());
      exp_rsp_q.delete();
      exp_bank_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_bank"}, 64'({bank_en, bank_we, bank_addr, bank_wdata}), 64'(0));
    chk({tag, "_rsp"},  64'({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 64'(0));
  endtask

  // Response monitor.
  rsp_t mr;
  always @(negedge clk) begin
    if (bus.rsp_valid != '0) begin
      if (exp_rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b, required none", bus.rsp_valid);
      end else begin
        mr = exp_rsp_q.pop_front();
        $display("rsp owner=%0d rdata=0x%08h err=%0d cyc=%0d", mr.owner, bus.rsp_rdata, bus.rsp_err, cyc);
        chk("rsp_owner", 64'(bus.rsp_valid), 64'(NR'(1) << mr.owner));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mr.rdata));
        chk("rsp_err",   64'(bus.rsp_err),   64'(mr.err));
        chk("rsp_cycle", 64'(cyc),           64'(mr.cyc));
      end
    end
  end

  // Bank-side monitor.
  bank_t mb;
  always @(negedge clk) begin
    if (bank_en != '0) begin
      if (exp_bank_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bank: bank_en=%b addr=%0d, required no access", bank_en, bank_addr);
      end else begin
        mb = exp_bank_q.pop_front();
        chk("bank_en",   64'(bank_en),   64'(mb.en));
        chk("bank_we",   64'(bank_we),   64'(mb.we));
        chk("bank_addr", 64'(bank_addr), 64'(mb.addr));
        if (mb.we) chk("bank_wdata", 64'(bank_wdata), 64'(mb.wdata));
      end
    end else if (bank_we) begin
      checks++; errors++;
      $display("FAIL idle_we: bank_we=1 with bank_en=0, required 0");
    end
  end

  // Protocol assertions.
  logic [NR-1:0] pv = '0;
  logic [NR-1:0] pr = '0;
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      assert (!(pv[i] && !pr[i] && !bus.req_valid[i])) else begin
        errors++;
        $display("FAIL valid_drop: req %0d dropped valid before ready", i);
      end
    end
    assert ($onehot0(bus.req_ready)) else begin
      errors++;
      $display("FAIL ready_onehot: req_ready=%b, required at most one bit", bus.req_ready);
    end
    pv <= bus.req_valid;
    pr <= bus.req_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  vec_t dir_v[$];
  vec_t v_abort;

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_width = {NR{SINGLE_WIDTH}};
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");

    // Round robin: 0,1,3 held valid across reset release, then req 0 again.
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(3);
    exp_grant_q.push_back(0);
    fork
      begin
        issue(mk(0, 1, 0, 10, 30'h0AAA, 4'b0001, 10, 4'b0000, 0, 30'h0, 0));
        repeat (2) @(posedge clk);
        #1;
        issue(mk(0, 0, 0, 20000, 30'h0, 4'b0010, 5664, 4'b0000, 0, 30'h3FFFF001, 0));
      end
      issue(mk(1, 1, 0, 20000, 30'h7001, 4'b0010, 5664, 4'b0000, 0, 30'h0, 0));
      issue(mk(3, 0, 0, 10, 30'h0, 4'b0001, 10, 4'b0000, 0, 30'h0AAA, 0));
      begin
        @(negedge clk);
        chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    drain();

    dir_v.push_back(mk(0, 1, 0, 5, 30'h1234, 4'b0001, 5, 4'b0000, 0, 30'h0, 0));
    dir_v.push_back(mk(0, 0, 0, 5, 30'h0, 4'b0001, 5, 4'b0000, 0, 30'h1234, 0));
    dir_v.push_back(mk(2, 1, 1, 14335, {15'h7FFF, 15'h0001}, 4'b0001, 14335, 4'b0010, 0, 30'h0, 0));
    dir_v.push_back(mk(2, 0, 1, 14335, 30'h0, 4'b0001, 14335, 4'b0010, 0, 30'h3FFF8001, 0));
    dir_v.push_back(mk(1, 1, 0, 40000, 30'h4000, 4'b0100, 11328, 4'b0000, 0, 30'h0, 0));
    dir_v.push_back(mk(1, 0, 0, 40000, 30'h0, 4'b0100, 11328, 4'b0000, 0, 30'h3FFFC000, 0));
    dir_v.push_back(mk(3, 0, 1, 57343, 30'h0, 4'b0000, 0, 4'b0000, 0, 30'h0, 1));
    dir_v.push_back(mk(3, 0, 0, 60000, 30'h0, 4'b0000, 0, 4'b0000, 0, 30'h0, 1));
    dir_v.push_back(mk(0, 1, 1, 57343, 30'h15555555, 4'b0000, 0, 4'b0000, 0, 30'h0, 1));
    foreach (dir_v[i]) begin
      issue(dir_v[i]);
      drain();
    end

    // Reset during ACC2 of a double write: both accesses occur, no response.
    v_abort = mk(2, 1, 1, 100, {15'h1111, 15'h2222}, 4'b0001, 100, 4'b0001, 101, 30'h0, 0, 1'b0);
    exp_grant_q.push_back(2);
    issue(v_abort);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("abort");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pointer back at 0: simultaneous 0 and 3 must serve 0 first.
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(3);
    fork
      issue(mk(0, 0, 0, 5, 30'h0, 4'b0001, 5, 4'b0000, 0, 30'h1234, 0));
      issue(mk(3, 0, 0, 40000, 30'h0, 4'b0100, 11328, 4'b0000, 0, 30'h3FFFC000, 0));
    join
    drain();

    chk("rsp_q_empty",   64'(exp_rsp_q.size()),   64'(0));
    chk("bank_q_empty",  64'(exp_bank_q.size()),  64'(0));
    chk("grant_q_empty", 64'(exp_grant_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
